// File: rtl/cmos_inv_pipe.sv
// Pipelined bank of switch-level CMOS inverter cells with a valid/ready handshake.
// Each beat carries its own mode (invert, pass or high-Z) through STAGES register slices.
module cmos_inv_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output wire logic [WIDTH-1:0] out_data,
  output logic                  mode_err,
  output logic [15:0]           beat_cnt
);

  typedef enum logic [1:0] {
    ModeInv  = 2'b00,
    ModePass = 2'b01,
    ModeRsvd = 2'b10,
    ModeHiz  = 2'b11
  } mode_e;

  supply0 gnd;
  supply1 vdd;

  wire [WIDTH-1:0] inv_w;
  wire [WIDTH-1:0] pass_w;

  // Pass mode is a second inverter pair fed by the first, so X/Z behave as a real cascade.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    pmos u_inv_p  (inv_w[i],  vdd, in_data[i]);
    nmos u_inv_n  (inv_w[i],  gnd, in_data[i]);
    pmos u_pass_p (pass_w[i], vdd, inv_w[i]);
    nmos u_pass_n (pass_w[i], gnd, inv_w[i]);
  end

  mode_e            mode;
  logic [WIDTH-1:0] xform_data;
  logic             xform_oe;

  assign mode = mode_e'(in_mode);

  // The reserved code falls through to invert.
  always_comb begin
    xform_data = inv_w;
    xform_oe   = 1'b1;
    case (mode)
      ModePass: xform_data = pass_w;
      ModeHiz: begin
        xform_data = '0;
        xform_oe   = 1'b0;
      end
      default: ;
    endcase
  end

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            oe_q;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            take;

  // take[k]: stage k may load this cycle (it is empty or its content moves on).
  always_comb begin
    take = '0;
    take[STAGES-1] = ~valid_q[STAGES-1] | out_ready;
    for (int unsigned k = STAGES - 1; k > 0; k--) begin
      take[k-1] = ~valid_q[k-1] | take[k];
    end
  end

  assign in_ready  = take[0];
  assign out_valid = valid_q[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      oe_q    <= '1;
      data_q  <= '0;
    end else begin
      if (take[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= xform_data;
          oe_q[0]   <= xform_oe;
        end
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (take[k]) begin
          valid_q[k] <= valid_q[k-1];
          // Bubbles leave the payload untouched so out_data does not flicker.
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            oe_q[k]   <= oe_q[k-1];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_err <= 1'b0;
    end else if (in_valid && in_ready && (mode == ModeRsvd)) begin
      mode_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (out_valid && out_ready) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

  logic [WIDTH-1:0] head_data;
  logic             head_oe;
  logic             head_oe_n;

  assign head_data = data_q[STAGES-1];
  assign head_oe   = oe_q[STAGES-1];
  assign head_oe_n = ~head_oe;

  // Per-bit transmission gate: both devices off when oe is low, leaving the bit floating.
  for (genvar i = 0; i < WIDTH; i++) begin : g_out
    nmos u_tg_n (out_data[i], head_data[i], head_oe);
    pmos u_tg_p (out_data[i], head_data[i], head_oe_n);
  end

endmodule

// File: tb/tb_cmos_inv_pipe.sv
// Directed bench for cmos_inv_pipe: reset, modes, back-pressure, reserved mode, reset, wrap.
module tb_cmos_inv_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  wire  [7:0]  out_data;
  logic        mode_err;
  logic [15:0] beat_cnt;

  int unsigned n_cmp;
  int unsigned n_bad;

  cmos_inv_pipe #(
    .WIDTH  (8),
    .STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mode_err  (mode_err),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 2'b00);
    #2;
    check("rst_valid", 16'(out_valid), 16'h0000);
    check("rst_data",  16'(out_data),  16'h0000);
    check("rst_err",   16'(mode_err),  16'h0000);
    check("rst_cnt",   beat_cnt,       16'h0000);
    check("rst_ready", 16'(in_ready),  16'h0001);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Invert stream, full throughput
    drive(1'b1, 8'hA5, 2'b00);
    cyc();
    check("inv_lat_valid", 16'(out_valid), 16'h0000);
    drive(1'b1, 8'h0F, 2'b00);
    cyc();
    check("inv0_valid", 16'(out_valid), 16'h0001);
    check("inv0_data",  16'(out_data),  16'h005A);
    drive(1'b1, 8'hFF, 2'b00);
    cyc();
    check("inv1_data", 16'(out_data), 16'h00F0);
    drive(1'b0, 8'h00, 2'b00);
    cyc();
    check("inv2_valid", 16'(out_valid), 16'h0001);
    check("inv2_data",  16'(out_data),  16'h0000);
    cyc();
    check("inv_drain", 16'(out_valid), 16'h0000);
    check("inv_cnt",   beat_cnt,       16'h0003);

    // Mixed modes: pass, high-Z, invert
    drive(1'b1, 8'h3C, 2'b01);
    cyc();
    drive(1'b1, 8'h3C, 2'b11);
    cyc();
    check("mix_pass", 16'(out_data), 16'h003C);
    drive(1'b1, 8'h3C, 2'b00);
    cyc();
    check("mix_hiz_valid", 16'(out_valid), 16'h0001);
    n_cmp++;
    assert (out_data === 8'hzz) else begin
      n_bad++;
      $error("FAIL mix_hiz_data: observed %h expected zz", out_data);
    end
    drive(1'b0, 8'h00, 2'b00);
    cyc();
    check("mix_inv", 16'(out_data), 16'h00C3);
    cyc();
    check("mix_cnt", beat_cnt, 16'h0006);

    // Back-pressure: 4 beats offered while downstream stalls
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 2'b00);
    #1;
    check("bp_ready0", 16'(in_ready), 16'h0001);
    cyc();
    drive(1'b1, 8'h22, 2'b00);
    #1;
    check("bp_ready1", 16'(in_ready), 16'h0001);
    cyc();
    drive(1'b1, 8'h33, 2'b00);
    #1;
    check("bp_full_ready", 16'(in_ready),  16'h0000);
    check("bp_head",       16'(out_data),  16'h00EE);
    cyc();
    check("bp_hold1_valid", 16'(out_valid), 16'h0001);
    check("bp_hold1_data",  16'(out_data),  16'h00EE);
    cyc();
    check("bp_hold2_data", 16'(out_data), 16'h00EE);
    check("bp_hold_cnt",   beat_cnt,      16'h0006);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 16'(in_ready), 16'h0001);
    cyc();
    check("bp_out1", 16'(out_data), 16'h00DD);
    drive(1'b1, 8'h44, 2'b00);
    cyc();
    check("bp_out2", 16'(out_data), 16'h00CC);
    drive(1'b0, 8'h00, 2'b00);
    cyc();
    check("bp_out3", 16'(out_data), 16'h00BB);
    cyc();
    check("bp_drain", 16'(out_valid), 16'h0000);
    check("bp_cnt",   beat_cnt,       16'h000A);

    // Reserved mode behaves as invert and latches mode_err
    drive(1'b1, 8'h81, 2'b10);
    cyc();
    check("rsv_err_set", 16'(mode_err), 16'h0001);
    drive(1'b1, 8'h00, 2'b01);
    cyc();
    check("rsv_data", 16'(out_data), 16'h007E);
    drive(1'b0, 8'h00, 2'b00);
    cyc();
    check("rsv_next_data", 16'(out_data), 16'h0000);
    check("rsv_err_sticky", 16'(mode_err), 16'h0001);
    cyc();
    check("rsv_cnt", beat_cnt, 16'h000C);

    // Reset with two beats in flight
    drive(1'b1, 8'hA5, 2'b00);
    cyc();
    drive(1'b1, 8'h5A, 2'b00);
    cyc();
    drive(1'b0, 8'h00, 2'b00);
    out_ready = 1'b0;
    #1;
    check("mid_pre_valid", 16'(out_valid), 16'h0001);
    rst_n = 1'b0;
    #1;
    check("mid_valid", 16'(out_valid), 16'h0000);
    check("mid_cnt",   beat_cnt,       16'h0000);
    check("mid_err",   16'(mode_err),  16'h0000);
    check("mid_data",  16'(out_data),  16'h0000);
    cyc();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h0F, 2'b00);
    cyc();
    drive(1'b0, 8'h00, 2'b00);
    check("post_lat_valid", 16'(out_valid), 16'h0000);
    cyc();
    check("post_valid", 16'(out_valid), 16'h0001);
    check("post_data",  16'(out_data),  16'h00F0);
    cyc();
    check("post_cnt", beat_cnt, 16'h0001);

    // Counter wrap: bring total to 65535, then one more
    drive(1'b1, 8'h96, 2'b01);
    repeat (65534) cyc();
    drive(1'b0, 8'h00, 2'b00);
    repeat (2) cyc();
    check("wrap_max", beat_cnt, 16'hFFFF);
    drive(1'b1, 8'h55, 2'b00);
    cyc();
    drive(1'b0, 8'h00, 2'b00);
    cyc();
    check("wrap_last_data", 16'(out_data), 16'h00AA);
    cyc();
    check("wrap_zero", beat_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
